// File: rtl/proc_trace_pkg.sv
// Shared types for the processor register trace capture block.
// Holds the capture FSM states and buffer mode encodings.
package proc_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_STOP = 1'b0;
    localparam logic MODE_CIRC = 1'b1;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port snapshot store, synchronous write and registered read.
// A read of the address being written returns the pre-write contents.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 144,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/reg_trace_capture.sv
// Register trace buffer: snapshots all GPRs with a cycle stamp whenever
// the trigger register changes; stop-when-full or circular storage.
module reg_trace_capture
    import proc_trace_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int DEPTH    = 16,
    parameter int TRIG_REG = 7,
    parameter int STAMP_W  = 16
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       Run,
    input  logic                       Clr,
    input  logic                       Mode,
    input  logic [STAMP_W-1:0]         Limit,
    input  logic [NUM_REGS*DATA_W-1:0] Regs,
    input  logic                       RdEn,
    output logic                       RdValid,
    output logic [NUM_REGS*DATA_W-1:0] RdData,
    output logic [STAMP_W-1:0]         RdStamp,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Overflow,
    output logic                       Done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = NUM_REGS * DATA_W;
    localparam int EW = RW + STAMP_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [STAMP_W-1:0] STAMP_ONE = STAMP_W'(1);

    state_e             state_q, state_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [DATA_W-1:0]  prev_q, prev_d;
    logic               first_q, first_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q;

    logic [DATA_W-1:0]  trig;
    logic               full, pop, ev, wr, ovw, drop, limit_hit;
    logic               ram_we, ram_re;
    logic [EW-1:0]      ram_rdata;

    assign trig = Regs[TRIG_REG*DATA_W +: DATA_W];
    assign full = (count_q == FULL_CNT);
    assign pop  = RdEn && (count_q != '0);
    assign ev   = (state_q == ARMED) && Run && (first_q || (trig != prev_q));
    // A same-edge pop frees a slot, so only an un-popped full buffer overflows.
    assign wr   = ev && ((Mode == MODE_CIRC) || !full || pop);
    assign ovw  = wr && full && !pop;
    assign drop = ev && !wr;
    assign limit_hit = (state_q == ARMED) && (Limit != '0) && (stamp_q == Limit);

    always_comb begin
        state_d  = state_q;
        stamp_d  = stamp_q;
        prev_d   = prev_q;
        first_d  = first_q;
        wr_ptr_d = wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = (pop || ovw) ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = ovf_q | drop | ovw;
        count_d  = count_q;
        if (wr && !pop && !ovw) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !wr) begin
            count_d = count_q - CNT_ONE;
        end
        unique case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d = ARMED;
                    first_d = 1'b1;
                end
            end
            ARMED: begin
                if (Run) begin
                    prev_d  = trig;
                    first_d = 1'b0;
                    if (!limit_hit && (stamp_q != '1)) begin
                        stamp_d = stamp_q + STAMP_ONE;
                    end
                end
                if (drop || limit_hit) begin
                    state_d = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Resetn || Clr) begin
            state_q  <= IDLE;
            stamp_q  <= '0;
            prev_q   <= '0;
            first_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stamp_q  <= stamp_d;
            prev_q   <= prev_d;
            first_q  <= first_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ram_we = wr && !Resetn && !Clr;
    assign ram_re = pop && !Resetn && !Clr;

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ram_re;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk_i   (Clock),
        .rst_i   (Resetn),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({Regs, stamp_q}),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign RdValid  = rd_valid_q;
    assign RdData   = ram_rdata[EW-1:STAMP_W];
    assign RdStamp  = ram_rdata[STAMP_W-1:0];
    assign Count    = count_q;
    assign Full     = full;
    assign Overflow = ovf_q;
    assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_reg_trace_capture.sv
// Directed bench for reg_trace_capture with DEPTH=4.
// Walks reset, capture, both full modes, limit, same-edge pop and clears.
module tb_reg_trace_capture;

    logic         Clock;
    logic         Resetn;
    logic         Run;
    logic         Clr;
    logic         Mode;
    logic [15:0]  Limit;
    logic [127:0] Regs;
    logic         RdEn;
    logic         RdValid;
    logic [127:0] RdData;
    logic [15:0]  RdStamp;
    logic [2:0]   Count;
    logic         Full;
    logic         Overflow;
    logic         Done;

    int checks = 0;
    int errors = 0;

    reg_trace_capture #(
        .DATA_W   (16),
        .NUM_REGS (8),
        .DEPTH    (4),
        .TRIG_REG (7),
        .STAMP_W  (16)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Run      (Run),
        .Clr      (Clr),
        .Mode     (Mode),
        .Limit    (Limit),
        .Regs     (Regs),
        .RdEn     (RdEn),
        .RdValid  (RdValid),
        .RdData   (RdData),
        .RdStamp  (RdStamp),
        .Count    (Count),
        .Full     (Full),
        .Overflow (Overflow),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [127:0] mk(input logic [15:0] r7);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 7; i++) begin
            v[i*16 +: 16] = r7 + 16'(i * 256);
        end
        v[112 +: 16] = r7;
        return v;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] r7,
                           input logic [15:0] st);
        RdEn = 1'b1;
        step();
        RdEn = 1'b0;
        chk({tag, ".valid"}, 128'(RdValid), 128'(1));
        chk({tag, ".data"}, RdData, mk(r7));
        chk({tag, ".stamp"}, 128'(RdStamp), 128'(st));
    endtask

    task automatic do_clr();
        Clr = 1'b1;
        step();
        Clr = 1'b0;
    endtask

    initial begin
        Resetn = 1'b1;
        Run    = 1'b0;
        Clr    = 1'b0;
        Mode   = 1'b0;
        Limit  = '0;
        Regs   = mk(16'd0);
        RdEn   = 1'b0;
        step();
        step();
        chk("rst.valid", 128'(RdValid), 128'(0));
        chk("rst.data", RdData, 128'(0));
        chk("rst.stamp", 128'(RdStamp), 128'(0));
        chk("rst.count", 128'(Count), 128'(0));
        chk("rst.full", 128'(Full), 128'(0));
        chk("rst.ovf", 128'(Overflow), 128'(0));
        chk("rst.done", 128'(Done), 128'(0));
        Resetn = 1'b0;

        // Basic capture: R7 = 0,1,2 with stamps 0,1,2
        Run = 1'b1;
        step();
        chk("t1.arm.count", 128'(Count), 128'(0));
        step();
        Regs = mk(16'd1);
        step();
        Regs = mk(16'd2);
        step();
        Run = 1'b0;
        chk("t1.count", 128'(Count), 128'(3));
        chk("t1.full", 128'(Full), 128'(0));
        pop_chk("t1.p0", 16'd0, 16'd0);
        pop_chk("t1.p1", 16'd1, 16'd1);
        pop_chk("t1.p2", 16'd2, 16'd2);
        RdEn = 1'b1;
        step();
        RdEn = 1'b0;
        chk("t1.empty.valid", 128'(RdValid), 128'(0));
        chk("t1.empty.count", 128'(Count), 128'(0));

        // Stop-when-full: six distinct values, first four kept
        do_clr();
        Mode = 1'b0;
        Regs = mk(16'd100);
        Run  = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            Regs = mk(16'(100 + i));
            step();
        end
        Run = 1'b0;
        chk("t2.count", 128'(Count), 128'(4));
        chk("t2.full", 128'(Full), 128'(1));
        chk("t2.ovf", 128'(Overflow), 128'(1));
        chk("t2.done", 128'(Done), 128'(1));
        pop_chk("t2.p0", 16'd100, 16'd0);
        pop_chk("t2.p1", 16'd101, 16'd1);
        pop_chk("t2.p2", 16'd102, 16'd2);
        pop_chk("t2.p3", 16'd103, 16'd3);
        chk("t2.done.after", 128'(Done), 128'(1));

        // Circular: R7 = 10..15 keeps the newest four
        do_clr();
        chk("clr.done", 128'(Done), 128'(0));
        chk("clr.ovf", 128'(Overflow), 128'(0));
        Mode = 1'b1;
        Regs = mk(16'd10);
        Run  = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            Regs = mk(16'(10 + i));
            step();
        end
        Run = 1'b0;
        chk("t3.count", 128'(Count), 128'(4));
        chk("t3.ovf", 128'(Overflow), 128'(1));
        chk("t3.done", 128'(Done), 128'(0));
        pop_chk("t3.p0", 16'd12, 16'd2);
        pop_chk("t3.p1", 16'd13, 16'd3);
        pop_chk("t3.p2", 16'd14, 16'd4);
        pop_chk("t3.p3", 16'd15, 16'd5);

        // Limit: DONE on the edge where stamp equals 5
        do_clr();
        Mode  = 1'b0;
        Limit = 16'd5;
        Regs  = mk(16'd50);
        Run   = 1'b1;
        step();
        repeat (5) step();
        chk("t4.done.pre", 128'(Done), 128'(0));
        chk("t4.count.pre", 128'(Count), 128'(1));
        step();
        chk("t4.done", 128'(Done), 128'(1));
        Regs = mk(16'd51);
        step();
        Run = 1'b0;
        chk("t4.count", 128'(Count), 128'(1));
        pop_chk("t4.p0", 16'd50, 16'd0);
        Limit = '0;

        // Full in stop mode with a same-edge pop: new entry accepted
        do_clr();
        Mode = 1'b0;
        Regs = mk(16'd200);
        Run  = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            Regs = mk(16'(200 + i));
            step();
        end
        chk("t5.full", 128'(Full), 128'(1));
        Regs = mk(16'd204);
        RdEn = 1'b1;
        step();
        RdEn = 1'b0;
        Run  = 1'b0;
        chk("t5.pop.valid", 128'(RdValid), 128'(1));
        chk("t5.pop.data", RdData, mk(16'd200));
        chk("t5.count", 128'(Count), 128'(4));
        chk("t5.ovf", 128'(Overflow), 128'(0));
        chk("t5.done", 128'(Done), 128'(0));
        pop_chk("t5.p1", 16'd201, 16'd1);
        pop_chk("t5.p2", 16'd202, 16'd2);
        pop_chk("t5.p3", 16'd203, 16'd3);
        pop_chk("t5.p4", 16'd204, 16'd4);

        // Reset in the middle of capturing
        do_clr();
        Regs = mk(16'd300);
        Run  = 1'b1;
        step();
        step();
        Regs = mk(16'd301);
        step();
        Regs = mk(16'd302);
        step();
        chk("t6.count.pre", 128'(Count), 128'(3));
        Regs   = mk(16'd303);
        Resetn = 1'b1;
        step();
        Resetn = 1'b0;
        chk("t6.rst.count", 128'(Count), 128'(0));
        chk("t6.rst.valid", 128'(RdValid), 128'(0));
        chk("t6.rst.data", RdData, 128'(0));
        chk("t6.rst.done", 128'(Done), 128'(0));
        Regs = mk(16'd300);
        step();
        chk("t6.rearm.count", 128'(Count), 128'(0));
        step();
        chk("t6.first.count", 128'(Count), 128'(1));
        Regs = mk(16'd301);
        step();
        Regs = mk(16'd302);
        step();
        chk("t6.count.refill", 128'(Count), 128'(3));
        pop_chk("t6.p0", 16'd300, 16'd0);
        Clr = 1'b1;
        step();
        Clr = 1'b0;
        Run = 1'b0;
        chk("t6.clr.count", 128'(Count), 128'(0));
        chk("t6.clr.valid", 128'(RdValid), 128'(0));
        chk("t6.clr.data", RdData, mk(16'd300));
        chk("t6.clr.done", 128'(Done), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_trace_capture.md
# reg_trace_capture

On-chip register trace buffer for the multicycle processor, parametrised in register count, data width and depth. It watches the processor's general-purpose register outputs and captures a snapshot of all registers, plus a cycle stamp, every time a designated trigger register (R7, the program counter, by default) changes value. The snapshots go into a readable buffer, which runs in either stop-when-full or circular mode. It is instantiated beside the processor in the top level, so register dumps and the run time limit are enforced in hardware instead of by the simulation harness.

## Interface
Parameters:
- DATA_W, 16, width of one processor register
- NUM_REGS, 8, number of registers observed (R0..R(NUM_REGS-1))
- DEPTH, 16, snapshot entries; power of two, ≥2
- TRIG_REG, 7, index of the trigger register
- STAMP_W, 16, cycle-stamp / limit width

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Resetn  in  1  synchronous, active-high reset (1 = reset); name kept for consistency with the processor
- Run  in  1  capture enable; IDLE→ARMED when 1; pauses capture and stamp when 0
- Clr  in  1  synchronous clear of buffer, flags and stamp; returns to IDLE
- Mode  in  1  0 = stop-when-full, 1 = circular overwrite
- Limit  in  STAMP_W  stamp value that forces DONE; 0 = no limit
- Regs  in  NUM_REGS*DATA_W  flattened registers, R0 in the LSBs
- RdEn  in  1  pop the oldest entry
- RdValid  out  1  RdData/RdStamp hold a popped entry this cycle
- RdData  out  NUM_REGS*DATA_W  popped register snapshot
- RdStamp  out  STAMP_W  stamp of the popped entry
- Count  out  $clog2(DEPTH)+1  entries held
- Full  out  1  Count == DEPTH
- Overflow  out  1  sticky; an event was dropped (mode 0) or overwrote an entry (mode 1)
- Done  out  1  state == DONE

## Operation
- States: IDLE, ARMED, DONE.
- IDLE:
  - Stamp is held at 0.
  - Goes to ARMED on the first edge with Run=1.
- ARMED, on each edge with Run=1:
  - Stamp increments by 1 and saturates at all-ones.
  - PrevTrig is loaded with the trigger register value.
  - A capture event occurs when the trigger register value differs from PrevTrig.
  - The first Run cycle after arming is always an event.
- Event in mode 0:
  - If not Full: write {Regs, Stamp} and increment Count.
  - If Full: drop the event, set Overflow, go to DONE.
- Event in mode 1:
  - If not Full: write and increment Count.
  - If Full: overwrite the oldest entry, advance the read pointer, keep Count = DEPTH, set Overflow.
- Limit: in ARMED, when Limit≠0 and Stamp == Limit, go to DONE on that edge. An event on the same edge is still captured.
- DONE: no captures and Stamp frozen. Reads remain allowed. Leaves only via Clr or Resetn.
- Reads:
  - RdEn with Count>0 pops the oldest entry.
  - RdEn with Count==0 is ignored; RdValid stays 0.
  - Reads work in every state.
- Simultaneous capture and pop:
  - Count is unchanged.
  - In mode 0 when Full, the pop frees a slot, so the event is written and Overflow is not set.
  - In mode 1 when Full, the popped entry is the pre-edge oldest entry. The write replaces it and advances the read pointer once only.
- Clr:
  - IDLE, Count=0, pointers=0, Overflow=0, Stamp=0, PrevTrig=0.
  - Has priority over Run, events and RdEn on the same edge.
- Resetn has the same effect as Clr and also clears RdValid, RdData and RdStamp.

## Timing
- Reset values: RdValid=0, RdData=0, RdStamp=0, Count=0, Full=0, Overflow=0, Done=0.
- Capture latency:
  - The event is detected and written on the same edge.
  - Count, Full and Overflow reflect it from the next cycle.
- Read latency: 1 cycle. RdEn sampled at edge k gives RdValid=1 with data during cycle k..k+1, for exactly one cycle per pop.
- Done asserts the cycle after the transition edge.
- Stamp is the value before the edge's increment: the first capture after arming carries Stamp=0.
- A Resetn assertion mid-capture discards partial state; the entry on that edge is not written.

## Structure
- Shared package proc_trace_pkg:
  - state enum {IDLE, ARMED, DONE}
  - mode constants MODE_STOP=0, MODE_CIRC=1
- Sub-module trace_ram:
  - simple dual-port, DEPTH × (NUM_REGS*DATA_W + STAMP_W)
  - synchronous write and synchronous read
- The top block holds the FSM, pointers, count, stamp counter and trigger compare.

## Test plan
- Reset then Run=1 with R7 stepping 0,1,2 on successive cycles → Count=3, pops return R7=0,1,2 with stamps 0,1,2.
- Mode 0, DEPTH=4, 6 distinct R7 values → Count=4, Overflow=1, Done=1, pops return the first 4 snapshots.
- Mode 1, DEPTH=4, R7 = 10..15 → Count=4, Overflow=1, pops return 12,13,14,15, Done=0.
- Limit=5, R7 constant after the first cycle → Done at Stamp=5, exactly 1 entry, Stamp stops at 5.
- Full with event and RdEn on the same edge, mode 0 → Count stays 4, Overflow=0, the new snapshot is last out.
- Resetn=1 mid-ARMED with Count=3 → next cycle Count=0, state IDLE, RdValid=0; Clr behaves the same without clearing RdData.
